// File: rtl/seg_scan_pkg.sv
// Shared encodings for the 7-segment scan scheduler: scan states,
// active-low segment glyphs and active-low anode selects.
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    an = AN_OFF;
    case (idx)
      2'd0: an = AN_DIG0;
      2'd1: an = AN_DIG1;
      2'd2: an = AN_DIG2;
      2'd3: an = AN_DIG3;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0: segments = SEG_HEX_0;
      4'h1: segments = SEG_HEX_1;
      4'h2: segments = SEG_HEX_2;
      4'h3: segments = SEG_HEX_3;
      4'h4: segments = SEG_HEX_4;
      4'h5: segments = SEG_HEX_5;
      4'h6: segments = SEG_HEX_6;
      4'h7: segments = SEG_HEX_7;
      4'h8: segments = SEG_HEX_8;
      4'h9: segments = SEG_HEX_9;
      4'hA: segments = SEG_HEX_A;
      4'hB: segments = SEG_HEX_B;
      4'hC: segments = SEG_HEX_C;
      4'hD: segments = SEG_HEX_D;
      4'hE: segments = SEG_HEX_E;
      4'hF: segments = SEG_HEX_F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// 4-digit multiplexed 7-segment scan with blanking dead-time and a shadow
// load buffer committed at frame boundaries. Optional SEG_SCAN_BRIGHTNESS_EN adds PWM dimming.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = 262144,
  parameter int BLANK_CYCLES = 1024,
  parameter int CNT_W        = 20
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_mask,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic        frame_tick,
  output logic [6:0]  C,
  output logic [3:0]  D
);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam scan_state_t      RESET_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       digit_idx;
  scan_state_t      state_q, state_d;
  logic [15:0]      active_data, pending_data;
  logic [3:0]       active_mask, pending_mask;
  logic             pending_full;
  logic             slot_wrap, frame_end, duty_on;
  logic [3:0]       active_nibble, d_next;
  logic [6:0]       hex_seg, c_next;

  assign slot_wrap     = (slot_cnt == SLOT_LAST);
  assign frame_end     = slot_wrap && (digit_idx == 2'd3);
  assign frame_tick    = frame_end;
  assign load_ready    = !pending_full;
  assign active_nibble = active_data[{digit_idx, 2'b00} +: 4];

  seg_hex_decoder u_hex (
    .nibble   (active_nibble),
    .segments (hex_seg)
  );

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
    end
  end

  // Commit wins over accept: a load landing on the frame boundary waits a full frame
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pending_full <= 1'b0;
      pending_data <= '0;
      pending_mask <= '0;
      active_data  <= '0;
      active_mask  <= '0;
    end else if (frame_end && pending_full) begin
      active_data  <= pending_data;
      active_mask  <= pending_mask;
      pending_full <= 1'b0;
    end else if (load_valid && load_ready) begin
      pending_data <= load_data;
      pending_mask <= load_mask;
      pending_full <= 1'b1;
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) pwm_cnt <= 4'd0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign duty_on = (pwm_cnt <= brightness);
`else
  assign duty_on = 1'b1;
`endif

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Masked digits blank their segments too, so a dark digit never drives C
  always_comb begin
    state_d = state_q;
    c_next  = SEG_BLANK;
    d_next  = AN_OFF;
    if (BLANK_CYCLES == 0) begin
      state_d = SHOW;
    end else begin
      case (state_q)
        BLANK:   if (slot_cnt == BLANK_LAST) state_d = SHOW;
        SHOW:    if (slot_wrap) state_d = BLANK;
        default: state_d = BLANK;
      endcase
    end
    if (state_q == SHOW && active_mask[digit_idx]) begin
      c_next = hex_seg;
      if (duty_on) d_next = anode_for(digit_idx);
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      C <= SEG_BLANK;
      D <= AN_OFF;
    end else begin
      C <= c_next;
      D <= d_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Self-checking bench for seg_scan_scheduler with 16-cycle slots and 4-cycle blanking.
module tb_seg_scan_scheduler;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  mask;
    logic [27:0] exp_c;
    logic [15:0] exp_d;
  } vec_t;

  localparam logic [6:0] BL = 7'b1111111;
  localparam vec_t DARK = {16'h0000, 4'b0000, {4{BL}}, 16'hFFFF};

  logic        clock_100Mhz = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_mask = '0;
  logic        load_ready, frame_tick;
  logic [6:0]  C;
  logic [3:0]  D;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'hF;
`endif

  int   checks = 0;
  int   errors = 0;
  int   pos = -1;
  vec_t q[$];
  vec_t cur = DARK;
  vec_t prev = DARK;
  vec_t vecs[5];

  seg_scan_scheduler #(
    .SLOT_CYCLES  (16),
    .BLANK_CYCLES (4),
    .CNT_W        (4)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_mask    (load_mask),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .brightness   (brightness),
`endif
    .frame_tick   (frame_tick),
    .C            (C),
    .D            (D)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (pos %0d)", name, actual, expected, pos);
    end
  endtask

  // Monitor: the queue holds the pending buffer contents; frames switch at each frame tick
  int   m, slot, cc;
  vec_t use_v;
  logic [6:0] e_c;
  logic [3:0] e_d;
  logic e_tick;

  always @(negedge clock_100Mhz) begin
    if (reset) begin
      q.delete();
      cur  = DARK;
      prev = DARK;
      pos  = -1;
      checkOutput("reset_C", {9'b0, C}, {9'b0, BL});
      checkOutput("reset_D", {12'b0, D}, 16'h000F);
      checkOutput("reset_ready", {15'b0, load_ready}, 16'h0001);
      checkOutput("reset_tick", {15'b0, frame_tick}, 16'h0000);
    end else begin
      pos++;
      checkOutput("load_ready", {15'b0, load_ready}, {15'b0, (q.size() == 0)});
      e_tick = ((pos % 64) == 63);
      checkOutput("frame_tick", {15'b0, frame_tick}, {15'b0, e_tick});
      if (e_tick) begin
        prev = cur;
        if (q.size() > 0) cur = q.pop_front();
      end
      m     = (pos + 63) % 64;
      slot  = m / 16;
      cc    = m % 16;
      use_v = (((pos + 1) % 64) < 2) ? prev : cur;
      if (cc < 4) begin
        e_c = BL;
        e_d = 4'b1111;
      end else begin
        e_c = use_v.exp_c[slot*7 +: 7];
        e_d = use_v.exp_d[slot*4 +: 4];
      end
      checkOutput("seg_C", {9'b0, C}, {9'b0, e_c});
      checkOutput("anode_D", {12'b0, D}, {12'b0, e_d});
    end
  end

  task automatic applyStimulus(input vec_t v, output bit waited, output bit tick_at_accept);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    waited = 1'b0;
    tick_at_accept = 1'b0;
    @(posedge clock_100Mhz);
    #1;
    load_data  = v.data;
    load_mask  = v.mask;
    load_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clock_100Mhz);
      #1;
      if (load_ready) begin
        acc = 1'b1;
        tick_at_accept = frame_tick;
      end else begin
        waited = 1'b1;
      end
      n++;
    end
    @(posedge clock_100Mhz);
    #1;
    load_valid = 1'b0;
    if (acc) q.push_back(v);
    else checkOutput("accept_timeout", 16'h0000, 16'h0001);
  endtask

  task automatic waitPos(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clock_100Mhz);
      #1;
      n++;
    end while ((pos % 64) != target && n < 200);
    if ((pos % 64) != target) checkOutput("wait_pos_timeout", 16'(pos % 64), 16'(target));
  endtask

  task automatic waitDisplayed();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clock_100Mhz);
      #1;
      n++;
    end
    if (q.size() != 0) checkOutput("commit_timeout", 16'(q.size()), 16'h0000);
    repeat (66) @(negedge clock_100Mhz);
  endtask

  bit waited, tick_acc;

  initial begin
    vecs[0] = {16'h3A0C, 4'b1111, {7'b0000110, 7'b0001000, 7'b0000001, 7'b0110001},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = {16'h8421, 4'b0101, {BL, 7'b1001100, BL, 7'b1001111},
               {4'b1111, 4'b1011, 4'b1111, 4'b1110}};
    vecs[2] = {16'hF6D9, 4'b1010, {7'b0111000, BL, 7'b1000010, BL},
               {4'b0111, 4'b1111, 4'b1101, 4'b1111}};
    vecs[3] = {16'h75B0, 4'b1111, {7'b0001111, 7'b0100100, 7'b1100000, 7'b0000001},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[4] = {16'h00E0, 4'b0010, {BL, BL, 7'b0110000, BL},
               {4'b1111, 4'b1111, 4'b1101, 4'b1111}};

    repeat (3) @(posedge clock_100Mhz);
    #1 reset = 1'b0;
    $display("[TB] reset released, idle frames");
    repeat (130) @(negedge clock_100Mhz);

    // Vector 1 is offered while vector 0 is still pending, so it must be held off
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], waited, tick_acc);
      if (i == 1) checkOutput("held_while_full", {15'b0, waited}, 16'h0001);
      if (i != 0) waitDisplayed();
    end

    $display("[TB] load coinciding with frame tick");
    waitPos(62);
    applyStimulus(vecs[0], waited, tick_acc);
    checkOutput("accept_on_tick", {15'b0, tick_acc}, 16'h0001);
    waitDisplayed();

    $display("[TB] reset during digit 2 show with a pending load");
    applyStimulus(vecs[3], waited, tick_acc);
    waitDisplayed();
    waitPos(10);
    applyStimulus(vecs[4], waited, tick_acc);
    waitPos(40);
    checkOutput("pre_reset_D", {12'b0, D}, 16'h000B);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_C", {9'b0, C}, {9'b0, BL});
    checkOutput("async_reset_D", {12'b0, D}, 16'h000F);
    checkOutput("async_reset_ready", {15'b0, load_ready}, 16'h0001);
    checkOutput("async_reset_tick", {15'b0, frame_tick}, 16'h0000);
    repeat (3) @(posedge clock_100Mhz);
    #1 reset = 1'b0;
    repeat (140) @(negedge clock_100Mhz);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
